// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit-check helper for the BCD-to-binary converter.
package bcd_pkg;

    localparam int NDIGITS = 3;
    localparam int BIN_W   = 10;
    localparam int STEPS   = 10;
    localparam int CNT_W   = 4;
    localparam int WORK_W  = 4 * NDIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // True when every 4-bit digit of the packed BCD word is in 0..9.
    function automatic logic digits_valid(input logic [WORK_W-1:0] w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (w[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for the reverse double-dabble step: subtract 3 when the digit is >= 8.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // A digit >= 8 after a right shift came from an odd upper digit; remove the excess 3.
    assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd_to_bin.sv
// Three-digit BCD to 10-bit binary converter, one bit per cycle (reverse double dabble).
module bcd_to_bin
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       Hund,
    input  logic [3:0]       Tens,
    input  logic [3:0]       Ones,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BIN_W-1:0] B
);

    state_t             state_reg;
    state_t             state_next;
    logic [WORK_W-1:0]  work_reg;
    logic [WORK_W-1:0]  work_shift;
    logic [WORK_W-1:0]  work_adj;
    logic [CNT_W-1:0]   cnt_reg;
    logic [BIN_W-1:0]   b_reg;
    logic               err_reg;
    logic               accept;
    logic               bad_digits;

    assign accept     = (state_reg == IDLE) && start;
    assign bad_digits = !digits_valid({Hund, Tens, Ones});
    assign work_shift = work_reg >> 1;

    // One correction unit per BCD digit of the shifted work register.
    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (work_shift[4*gi +: 4]),
                .dout (work_adj[4*gi +: 4])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: bad digits skip straight to DONE, otherwise STEPS shift cycles.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = bad_digits ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_reg == CNT_W'(STEPS - 1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch digits on acceptance, then shift one bit into B per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_reg <= '0;
            cnt_reg  <= '0;
            b_reg    <= '0;
            err_reg  <= 1'b0;
        end else if (accept) begin
            work_reg <= {Hund, Tens, Ones};
            cnt_reg  <= '0;
            b_reg    <= '0;
            err_reg  <= bad_digits;
        end else if (state_reg == SHIFT) begin
            work_reg <= work_adj;
            b_reg    <= {work_reg[0], b_reg[BIN_W-1:1]};
            cnt_reg  <= cnt_reg + 1'b1;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign err  = err_reg;
    assign B    = b_reg;

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 The block SHALL have no parameters; widths are fixed by constants in bcd_pkg (NDIGITS=3, BIN_W=10, STEPS=10).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to convert; sampled only in IDLE.
REQ-005 Hund  input  4  BCD hundreds digit.
REQ-006 Tens  input  4  BCD tens digit.
REQ-007 Ones  input  4  BCD ones digit.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse; result and err valid while high.
REQ-010 err  output  1  high with done when any latched digit > 9.
REQ-011 B  output  10  binary result, 0..999.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 at edge k SHALL latch Hund/Tens/Ones into a 12-bit work register, clear the step counter and clear the B shift register.
REQ-014 If any latched digit > 9 at edge k, the FSM SHALL go IDLE->DONE with err=1 and B=0, so done is high in the cycle after edge k.
REQ-015 Otherwise the FSM SHALL go IDLE->SHIFT with err=0.
REQ-016 Each SHIFT edge SHALL perform one step:
- shift the work register right one bit;
- shift B right one bit, with the bit shifted out of the work register entering B[9];
- then subtract 3 from each 4-bit work digit whose shifted value is >= 8.
REQ-017 After step STEPS (edge k+10) the FSM SHALL enter DONE, so done is high in the cycle after edge k+10: latency 10 cycles from acceptance.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE; done=1 only in DONE.
REQ-019 B and err SHALL hold their values from DONE until the next accepted start.
REQ-020 start while busy=1 SHALL be ignored, including start in the DONE cycle; a new start is accepted no earlier than the first IDLE cycle.
REQ-021 Digit inputs SHALL be ignored except at the acceptance edge.
REQ-022 The work register SHALL be all-zero on entry to DONE for every valid input; this is a checkable invariant.
REQ-023 All arithmetic SHALL be unsigned, 4-bit per digit; subtract-3 never underflows because it applies only to values >= 8.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, err=0, B=0, work register=0 and counter=0, including during SHIFT or DONE.
REQ-025 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-026 bcd_pkg SHALL hold NDIGITS, BIN_W, STEPS, the state enum type and the counter width (4 bits).
REQ-027 Per-digit correction (input 4-bit, output 4-bit, subtract 3 if >= 8) SHALL be the sub-module bcd_digit_adj, instantiated NDIGITS times.
REQ-028 No output SHALL be driven combinationally from the inputs; busy, done, err and B are registered or decoded from state only.

Verification
REQ-029 Valid conversion, 9/9/9: Hund=9, Tens=9, Ones=9, start pulse -> done 10 cycles later, B=999 (0x3E7), err=0, busy high for 11 cycles.
REQ-030 Zero and mid-range: 0/0/0 -> B=0, err=0; 2/5/5 -> B=255, err=0; 1/2/8 -> B=128.
REQ-031 Invalid digit: Hund=1, Tens=0xA, Ones=0 -> done 1 cycle after acceptance, err=1, B=0.
REQ-032 Start while busy: start 0/4/2 then, mid-SHIFT, start with 9/9/9 and different digits -> only B=42 is produced, with one done pulse.
REQ-033 Reset mid-conversion: rst_n low at step 5 -> busy, done and B are 0 immediately; after release, 3/0/7 -> B=307.
REQ-034 Exhaustive sweep: all 1000 valid inputs back-to-back -> B matches 100*H + 10*T + O, and the work register is zero at DONE.
